// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB slave register bank.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  localparam logic APB_OKAY   = 1'b0;
  localparam logic APB_SLVERR = 1'b1;

  // Byte-offset width of one data word
  function automatic int unsigned addr_lsb(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/apb_regbank_decode.sv
// Address decode: byte address -> register index plus hit/misaligned/read-only flags.
module apb_regbank_decode
  import apb_pkg::*;
#(
  parameter int unsigned         ADDR_W   = 32,
  parameter int unsigned         DATA_W   = 32,
  parameter int unsigned         NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0,
  parameter int unsigned         IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic [ADDR_W-1:0] paddr_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic              hit_o,
  output logic              misaligned_o,
  output logic              ro_hit_o
);

  localparam int unsigned       LSB       = addr_lsb(DATA_W);
  localparam logic [ADDR_W-1:0] NumRegsA  = ADDR_W'(NUM_REGS);

  logic [ADDR_W-1:0] word;

  if (LSB > 0) begin : g_align
    assign misaligned_o = |paddr_i[LSB-1:0];
  end else begin : g_no_align
    assign misaligned_o = 1'b0;
  end

  // Word index, range check and read-only lookup
  always_comb begin
    word     = paddr_i >> LSB;
    idx_o    = word[IDX_W-1:0];
    hit_o    = (word < NumRegsA);
    ro_hit_o = hit_o & RO_MASK[idx_o];
  end

endmodule

// File: rtl/apb_slave_regbank.sv
// APB slave register bank with byte strobes, wait states, PSLVERR and read-only status regs.
module apb_slave_regbank
  import apb_pkg::*;
#(
  parameter int unsigned         ADDR_W      = 32,
  parameter int unsigned         DATA_W      = 32,
  parameter int unsigned         NUM_REGS    = 16,
  parameter int unsigned         WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
  parameter logic [DATA_W-1:0]   RESET_VAL   = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [ADDR_W-1:0]            paddr_i,
  input  logic                         pselx_i,
  input  logic                         penable_i,
  input  logic                         pwrite_i,
  input  logic [DATA_W-1:0]            pwdata_i,
  input  logic [DATA_W/8-1:0]          pstrb_i,
  output logic                         pready_o,
  output logic [DATA_W-1:0]            prdata_o,
  output logic                         pslverr_o,
  input  logic [NUM_REGS*DATA_W-1:0]   ro_in_i,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q_o,
  output logic [NUM_REGS-1:0]          wr_pulse_o
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  apb_state_e          state_q, state_d;
  logic [3:0]          wait_cnt_q, wait_cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                write_q, write_d;
  logic                err_q, err_d;
  logic                ro_q, ro_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]       strb_q, strb_d;
  logic [DATA_W-1:0]   prdata_q, prdata_d;
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
  logic                wr_en;

  logic [IDX_W-1:0]    dec_idx;
  logic                dec_hit, dec_misaligned, dec_ro_hit;

  logic [NUM_REGS*DATA_W-1:0] reg_flat;
  logic [DATA_W-1:0]          rd_word;

  apb_regbank_decode #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .RO_MASK  (RO_MASK),
    .IDX_W    (IDX_W)
  ) u_decode (
    .paddr_i      (paddr_i),
    .idx_o        (dec_idx),
    .hit_o        (dec_hit),
    .misaligned_o (dec_misaligned),
    .ro_hit_o     (dec_ro_hit)
  );

  // Read source for the captured index: live status input or stored register
  always_comb begin
    rd_word = ro_q ? ro_in_i[idx_q*DATA_W +: DATA_W] : reg_flat[idx_q*DATA_W +: DATA_W];
  end

  // Outputs depend only on registered state
  assign pready_o   = (state_q == ACCESS) && (wait_cnt_q == 4'd0);
  assign pslverr_o  = pready_o ? err_q : APB_OKAY;
  assign prdata_o   = prdata_q;
  assign reg_q_o    = reg_flat;
  assign wr_pulse_o = wr_pulse_q;

  // FSM next-state, transfer capture and write commit decision
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    idx_d      = idx_q;
    write_d    = write_q;
    err_d      = err_q;
    ro_d       = ro_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    prdata_d   = prdata_q;
    wr_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        prdata_d = '0;
        if (pselx_i && !penable_i) begin
          state_d = SETUP;
          idx_d   = dec_idx;
          write_d = pwrite_i;
          wdata_d = pwdata_i;
          strb_d  = pstrb_i;
          ro_d    = dec_ro_hit;
          err_d   = (dec_misaligned || !dec_hit || (pwrite_i && dec_ro_hit)) ?
                    APB_SLVERR : APB_OKAY;
        end
      end
      SETUP: begin
        state_d    = ACCESS;
        wait_cnt_d = 4'(WAIT_STATES);
        if (!write_q) prdata_d = err_q ? '0 : rd_word;
      end
      ACCESS: begin
        if (!pselx_i) begin
          // Master abandoned the transfer: no write, no response
          state_d    = IDLE;
          wait_cnt_d = 4'd0;
          prdata_d   = '0;
        end else if (wait_cnt_q != 4'd0) begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end else if (penable_i) begin
          state_d  = IDLE;
          prdata_d = '0;
          wr_en    = write_q && !err_q;
        end
      end
      default: state_d = IDLE;
    endcase
    wr_pulse_d = wr_en ? (NUM_REGS'(1) << idx_q) : '0;
  end

  // Control and transfer state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      wait_cnt_q <= 4'd0;
      idx_q      <= '0;
      write_q    <= 1'b0;
      err_q      <= APB_OKAY;
      ro_q       <= 1'b0;
      wdata_q    <= '0;
      strb_q     <= '0;
      prdata_q   <= '0;
      wr_pulse_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      idx_q      <= idx_d;
      write_q    <= write_d;
      err_q      <= err_d;
      ro_q       <= ro_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      prdata_q   <= prdata_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (RO_MASK[i]) begin : g_ro
      assign reg_flat[i*DATA_W +: DATA_W] = '0;
    end else begin : g_rw
      logic [DATA_W-1:0] r_q;
      // Byte-strobed update on write commit
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_q <= RESET_VAL;
        end else if (wr_en && (idx_q == IDX_W'(i))) begin
          for (int b = 0; b < NB; b++) begin
            if (strb_q[b]) r_q[8*b +: 8] <= wdata_q[8*b +: 8];
          end
        end
      end
      assign reg_flat[i*DATA_W +: DATA_W] = r_q;
    end
  end

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed self-checking bench: three instances (0/3/2 wait states) share one APB bus.
module tb_apb_slave_regbank;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   paddr;
  logic [2:0]    psel;
  logic          penable, pwrite;
  logic [31:0]   pwdata;
  logic [3:0]    pstrb;
  logic [511:0]  ro_in;

  logic          pready  [3];
  logic [31:0]   prdata  [3];
  logic          pslverr [3];
  logic [511:0]  regq    [3];
  logic [15:0]   wrp     [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_slave_regbank #(.WAIT_STATES(0), .RO_MASK(16'h0008)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .paddr_i(paddr), .pselx_i(psel[0]), .penable_i(penable),
    .pwrite_i(pwrite), .pwdata_i(pwdata), .pstrb_i(pstrb), .pready_o(pready[0]),
    .prdata_o(prdata[0]), .pslverr_o(pslverr[0]), .ro_in_i(ro_in), .reg_q_o(regq[0]),
    .wr_pulse_o(wrp[0])
  );

  apb_slave_regbank #(.WAIT_STATES(3)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .paddr_i(paddr), .pselx_i(psel[1]), .penable_i(penable),
    .pwrite_i(pwrite), .pwdata_i(pwdata), .pstrb_i(pstrb), .pready_o(pready[1]),
    .prdata_o(prdata[1]), .pslverr_o(pslverr[1]), .ro_in_i(ro_in), .reg_q_o(regq[1]),
    .wr_pulse_o(wrp[1])
  );

  apb_slave_regbank #(.WAIT_STATES(2), .RESET_VAL(32'hA5A5_0000)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .paddr_i(paddr), .pselx_i(psel[2]), .penable_i(penable),
    .pwrite_i(pwrite), .pwdata_i(pwdata), .pstrb_i(pstrb), .pready_o(pready[2]),
    .prdata_o(prdata[2]), .pslverr_o(pslverr[2]), .ro_in_i(ro_in), .reg_q_o(regq[2]),
    .wr_pulse_o(wrp[2])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] slot(input int inst, input int r);
    return regq[inst][r*32 +: 32];
  endfunction

  // One full transfer; lows counts access-phase cycles with pready low
  task automatic apb_xfer(input int inst, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          output logic [31:0] rdata, output logic err,
                          output int lows, output logic stable);
    logic [31:0] first;
    lows   = 0;
    stable = 1'b1;
    first  = '0;
    @(posedge clk); #1;
    psel[inst] = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    while (!pready[inst] && lows < 40) begin
      if (lows == 1) first = prdata[inst];
      else if (lows > 1 && prdata[inst] !== first) stable = 1'b0;
      lows++;
      @(negedge clk);
    end
    if (lows >= 2 && prdata[inst] !== first) stable = 1'b0;
    check("xfer_done", {63'b0, pready[inst]}, 64'd1);
    rdata = prdata[inst];
    err   = pslverr[inst];
    @(posedge clk); #1;
    psel[inst] = 1'b0; penable = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lows;
    logic        st;

    rst_n = 1'b0; psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    pstrb = '0; ro_in = '0; ro_in[3*32 +: 32] = 32'h0000_1234;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pready",  {63'b0, pready[0]}, 64'd0);
    check("rst_prdata",  {32'b0, prdata[0]}, 64'd0);
    check("rst_pslverr", {63'b0, pslverr[0]}, 64'd0);
    check("rst_wrp",     {48'b0, wrp[0]}, 64'd0);
    check("rst_reg0_2",  {32'b0, slot(0, 2)}, 64'd0);
    check("rst_reg2_1",  {32'b0, slot(2, 1)}, 64'hA5A5_0000);
    @(posedge clk); #1 rst_n = 1'b1;

    // Reset asserted in ACCESS of a write (2 wait states): aborted, no update
    @(posedge clk); #1;
    psel[2] = 1'b1; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'h1234_5678; pstrb = 4'hF;
    penable = 1'b0;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("midrst_pready",  {63'b0, pready[2]}, 64'd0);
    check("midrst_pslverr", {63'b0, pslverr[2]}, 64'd0);
    check("midrst_prdata",  {32'b0, prdata[2]}, 64'd0);
    check("midrst_wrp",     {48'b0, wrp[2]}, 64'd0);
    check("midrst_reg",     {32'b0, slot(2, 1)}, 64'hA5A5_0000);
    psel[2] = 1'b0; penable = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    // Full-word write with no wait states, then read back
    apb_xfer(0, 1'b1, 32'h08, 32'hDEAD_BEEF, 4'hF, rd, er, lows, st);
    check("wr08_lows", 64'(lows), 64'd1);
    check("wr08_err",  {63'b0, er}, 64'd0);
    check("wr08_wrp",  {48'b0, wrp[0]}, 64'h0004);
    check("wr08_reg",  {32'b0, slot(0, 2)}, 64'hDEAD_BEEF);
    @(posedge clk); #1;
    check("wr08_wrp_off", {48'b0, wrp[0]}, 64'd0);
    apb_xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, rd, er, lows, st);
    check("rd08_data", {32'b0, rd}, 64'hDEAD_BEEF);
    check("rd08_err",  {63'b0, er}, 64'd0);
    @(negedge clk);
    check("rd08_prdata_clr", {32'b0, prdata[0]}, 64'd0);
    check("rd08_pready_off", {63'b0, pready[0]}, 64'd0);

    // Byte strobes
    apb_xfer(0, 1'b1, 32'h04, 32'h1122_3344, 4'hF, rd, er, lows, st);
    apb_xfer(0, 1'b1, 32'h04, 32'hAABB_CCDD, 4'b0101, rd, er, lows, st);
    check("strb_reg", {32'b0, slot(0, 1)}, 64'h11BB_33DD);
    apb_xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, rd, er, lows, st);
    check("strb_rd", {32'b0, rd}, 64'h11BB_33DD);

    // Zero-strobe write: legal no-op that still pulses
    apb_xfer(0, 1'b1, 32'h00, 32'hFFFF_FFFF, 4'h0, rd, er, lows, st);
    check("strb0_err", {63'b0, er}, 64'd0);
    check("strb0_wrp", {48'b0, wrp[0]}, 64'h0001);
    check("strb0_reg", {32'b0, slot(0, 0)}, 64'd0);

    // Three wait states: read holds prdata stable while pready is low
    apb_xfer(1, 1'b1, 32'h0C, 32'hCAFE_F00D, 4'hF, rd, er, lows, st);
    check("ws3_wr_lows", 64'(lows), 64'd4);
    apb_xfer(1, 1'b0, 32'h0C, 32'h0, 4'h0, rd, er, lows, st);
    check("ws3_rd_lows",   64'(lows), 64'd4);
    check("ws3_rd_data",   {32'b0, rd}, 64'hCAFE_F00D);
    check("ws3_rd_stable", {63'b0, st}, 64'd1);

    // Error responses
    apb_xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, rd, er, lows, st);
    check("oor_err",  {63'b0, er}, 64'd1);
    check("oor_data", {32'b0, rd}, 64'd0);
    apb_xfer(0, 1'b1, 32'h05, 32'hFFFF_FFFF, 4'hF, rd, er, lows, st);
    check("mis_err", {63'b0, er}, 64'd1);
    check("mis_wrp", {48'b0, wrp[0]}, 64'd0);
    check("mis_reg", {32'b0, slot(0, 1)}, 64'h11BB_33DD);
    apb_xfer(0, 1'b1, 32'h0C, 32'hFFFF_FFFF, 4'hF, rd, er, lows, st);
    check("ro_wr_err", {63'b0, er}, 64'd1);
    check("ro_wr_wrp", {48'b0, wrp[0]}, 64'd0);
    check("ro_reg_q",  {32'b0, slot(0, 3)}, 64'd0);
    apb_xfer(0, 1'b0, 32'h0C, 32'h0, 4'h0, rd, er, lows, st);
    check("ro_rd_err",  {63'b0, er}, 64'd0);
    check("ro_rd_data", {32'b0, rd}, 64'h0000_1234);

    // Master drops pselx in ACCESS (2 wait states): no write, then a normal transfer
    @(posedge clk); #1;
    psel[2] = 1'b1; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h0000_0055; pstrb = 4'hF;
    penable = 1'b0;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 psel[2] = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    check("abort_wrp", {48'b0, wrp[2]}, 64'd0);
    check("abort_reg", {32'b0, slot(2, 2)}, 64'hA5A5_0000);
    @(negedge clk);
    check("abort_pready", {63'b0, pready[2]}, 64'd0);
    apb_xfer(2, 1'b1, 32'h08, 32'h0000_0077, 4'hF, rd, er, lows, st);
    check("post_abort_lows", 64'(lows), 64'd3);
    check("post_abort_wrp",  {48'b0, wrp[2]}, 64'h0004);
    apb_xfer(2, 1'b0, 32'h08, 32'h0, 4'h0, rd, er, lows, st);
    check("post_abort_rd", {32'b0, rd}, 64'h0000_0077);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
